ram_loader: RTL

//  Write-side master for the 16x8 SAP-1 program RAM. Accepts a byte stream over a

---
 rtl/ram_loader_pkg.sv | 7 +
 rtl/ram_loader_if.sv | 18 +
 rtl/ram_loader_addr_counter.sv | 17 +
 rtl/ram_loader.sv | 109 ++++++++++
 4 files changed

// File: rtl/ram_loader_pkg.sv
// ram_loader_pkg: shared widths and loader state encoding for the SAP-1 program RAM loader.
package ram_loader_pkg;
   localparam int SAP_ADDR_W = 4;
   localparam int SAP_DATA_W = 8;
   localparam int SAP_DEPTH  = 1 << SAP_ADDR_W;
   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WRITE, S_VDRV, S_VCHK, S_DONE} state_t;
endpackage

// File: rtl/ram_loader_if.sv
// ram_loader_if: byte-stream handshake plus RAM write/readback bus of the program loader.
interface ram_loader_if import ram_loader_pkg::*; #(
   parameter int ADDR_W = SAP_ADDR_W,
   parameter int DATA_W = SAP_DATA_W
);
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_address;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_enable;
   logic [DATA_W-1:0] w_bus;
   modport master (input in_valid, in_data, w_bus,
                   output in_ready, mem_we, mem_address, mem_wdata, mem_enable);
   modport slave  (output in_valid, in_data, w_bus,
                   input in_ready, mem_we, mem_address, mem_wdata, mem_enable);
endinterface

// File: rtl/ram_loader_addr_counter.sv
// addr_counter: W-bit clear/increment counter with terminal-count flag, also usable as a program counter.
module addr_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count,
   output logic         tc
);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) count <= '0;
      else if (clr) count <= '0;
      else if (inc) count <= count + 1'b1;
   assign tc = &count;
endmodule

// File: rtl/ram_loader.sv
// ram_loader: writes a byte stream into RAM addresses 0..DEPTH-1; optional readback
// checksum verify when RAM_VERIFY_EN is defined.
module ram_loader import ram_loader_pkg::*; #(
   parameter int ADDR_W = SAP_ADDR_W,
   parameter int DATA_W = SAP_DATA_W
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   ram_loader_if.master   bus,
   output logic           busy,
   output logic           done,
   output logic           error
);
   state_t            state;
   logic [DATA_W-1:0] csum;
   logic [ADDR_W-1:0] addr;
   logic              tc;
`ifdef RAM_VERIFY_EN
   logic [DATA_W-1:0] rd_sum;
`else
   assign error          = 1'b0;
   assign bus.mem_enable = 1'b0;
`endif

   addr_counter #(.W(ADDR_W)) u_cnt (
      .clk(clk),
      .rst_n(rst_n),
      .clr(state == S_IDLE && start),
      .inc(state == S_WRITE || state == S_VCHK),
      .count(addr),
      .tc(tc)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= S_IDLE;
         csum            <= '0;
         busy            <= 1'b0;
         done            <= 1'b0;
         bus.in_ready    <= 1'b0;
         bus.mem_we      <= 1'b0;
         bus.mem_address <= '0;
         bus.mem_wdata   <= '0;
`ifdef RAM_VERIFY_EN
         error           <= 1'b0;
         rd_sum          <= '0;
         bus.mem_enable  <= 1'b0;
`endif
      end else begin
         done       <= 1'b0;
         bus.mem_we <= 1'b0;
         case (state)
            S_IDLE: if (start) begin
               state        <= S_LOAD;
               busy         <= 1'b1;
               bus.in_ready <= 1'b1;
               csum         <= '0;
`ifdef RAM_VERIFY_EN
               error        <= 1'b0;
               rd_sum       <= '0;
`endif
            end
            S_LOAD: if (bus.in_valid && bus.in_ready) begin
               state           <= S_WRITE;
               bus.in_ready    <= 1'b0;
               bus.mem_we      <= 1'b1;
               bus.mem_address <= addr;
               bus.mem_wdata   <= bus.in_data;
               csum            <= csum ^ bus.in_data;
            end
            // the counter wraps to 0 on the last write, ready for the readback pass
            S_WRITE: if (!tc) begin
               state        <= S_LOAD;
               bus.in_ready <= 1'b1;
            end else begin
`ifdef RAM_VERIFY_EN
               state           <= S_VDRV;
               bus.mem_enable  <= 1'b1;
               bus.mem_address <= '0;
`else
               state <= S_DONE;
               done  <= 1'b1;
`endif
            end
`ifdef RAM_VERIFY_EN
            S_VDRV: state <= S_VCHK;
            S_VCHK: begin
               rd_sum <= rd_sum ^ bus.w_bus;
               if (tc) begin
                  state          <= S_DONE;
                  done           <= 1'b1;
                  bus.mem_enable <= 1'b0;
                  error          <= (rd_sum ^ bus.w_bus) != csum;
               end else begin
                  state           <= S_VDRV;
                  bus.mem_address <= addr + 1'b1;
               end
            end
`endif
            S_DONE: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule
